multicycle_controller: RTL and testbench

//  Main control FSM for the multi-cycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).

---
 rtl/multicycle_controller.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
// Drives the shared datapath selects and a req/ready memory handshake with a wait timeout.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       illegal,
    output logic       bus_error,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_error_q, bus_error_d;

    logic [2:0] alu_dec;
    logic       alu_ok;
    logic       mem_state;
    logic       timeout;

    logic mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;

    // ALU operation decode from funct3 (I-type never subtracts)
    always_comb begin
        alu_dec = 3'b000;
        alu_ok  = 1'b1;
        case (funct3)
            3'b000:  alu_dec = (op[5] & funct7b5) ? 3'b001 : 3'b000;
            3'b010:  alu_dec = 3'b101;
            3'b110:  alu_dec = 3'b011;
            3'b111:  alu_dec = 3'b010;
            default: alu_ok  = 1'b0;
        endcase
    end

    // Immediate format follows op in every state
    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Wait counter: counts stalled memory cycles, clears on any state change or timeout retry
    always_comb begin
        mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
        timeout   = mem_state && !mem_ready && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
        cnt_d     = (mem_state && !mem_ready && !timeout) ? cnt_q + CNT_W'(1) : '0;
    end

    // Next-state and Moore outputs; write strobes gated by mem_ready/zero
    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q | timeout;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        adr_src     = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        case (state_q)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready)    state_d = S_MEMWB;
                else if (timeout) state_d = S_FETCH;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src     = 1'b1;
                if (mem_ready || timeout) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                alu_control = alu_dec;
                if (alu_ok) begin
                    state_d = S_ALUWB;
                end else begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a   = 2'b10;
                alu_control = 3'b001;
                state_d     = S_FETCH;
                if (funct3 == 3'b000) pc_write_c = zero;
                else                  illegal_d  = 1'b1;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_c = 1'b1;
                state_d    = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State, wait counter and sticky error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            cnt_q       <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Strobes are masked by reset directly so an access aborts the moment reset asserts
    assign mem_req   = mem_req_c   & reset;
    assign mem_write = mem_write_c & reset;
    assign ir_write  = ir_write_c  & reset;
    assign pc_write  = pc_write_c  & reset;
    assign reg_write = reg_write_c & reset;
    assign illegal   = illegal_q;
    assign bus_error = bus_error_q;
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios followed by random
// instructions, checked each cycle against an instruction-level reference model.
module tb_multicycle_controller;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic       illegal, bus_error;
    logic [3:0] state;

    multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .imm_src(imm_src), .illegal(illegal),
        .bus_error(bus_error), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    typedef struct packed {
        logic [3:0] st;
        logic       mreq, mwr, adr, irw, pcw, rw;
        logic [1:0] rs, sa, sb;
        logic [2:0] alu;
    } ctl_t;

    typedef struct {
        int st;
        bit rdy;
        bit set_ill;
        bit set_bus;
    } step_t;

    step_t q[$];
    int    passed = 0;
    int    total  = 0;
    bit    ill_m  = 1'b0;
    bit    bus_m  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Control word the table prescribes for each state
    function automatic ctl_t exp_ctl(int st, logic rdy, logic z, logic [6:0] o,
                                     logic [2:0] f3, logic f7);
        ctl_t c;
        logic [2:0] a;
        c = '0;
        c.st = 4'(st);
        case (f3)
            3'b000:  a = (o == RT && f7) ? 3'b001 : 3'b000;
            3'b010:  a = 3'b101;
            3'b110:  a = 3'b011;
            3'b111:  a = 3'b010;
            default: a = 3'b000;
        endcase
        case (st)
            0:  begin c.mreq = 1; c.sb = 2; c.rs = 2; c.irw = rdy; c.pcw = rdy; end
            1:  begin c.sa = 1; c.sb = 1; end
            2:  begin c.sa = 2; c.sb = 1; end
            3:  begin c.mreq = 1; c.adr = 1; end
            4:  begin c.rs = 1; c.rw = 1; end
            5:  begin c.mreq = 1; c.mwr = 1; c.adr = 1; end
            6:  begin c.sa = 2; c.alu = a; end
            7:  begin c.sa = 2; c.sb = 1; c.alu = a; end
            8:  begin c.rw = 1; end
            9:  begin c.sa = 2; c.alu = 3'b001; c.pcw = z && (f3 == 3'b000); end
            10: begin c.sa = 1; c.sb = 2; c.pcw = 1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] exp_imm(logic [6:0] o);
        if (o == SW) return 2'b01;
        if (o == BQ) return 2'b10;
        if (o == JL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit f3_alu_ok(logic [2:0] f3);
        return f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111;
    endfunction

    // A memory phase: w stalled cycles then one ready cycle; a stall run reaching TO times out
    task automatic add_mem(input int st, input int w, output bit aborted);
        int c = 0;
        aborted = 0;
        for (int i = 0; i < w; i++) begin
            c++;
            q.push_back('{st, 1'b0, 1'b0, c == TO});
            if (c == TO) begin
                c = 0;
                if (st != 0) begin
                    aborted = 1;
                    return;
                end
            end
        end
        q.push_back('{st, 1'b1, 1'b0, 1'b0});
    endtask

    // One instruction: build its state walk, then step it cycle by cycle checking every output
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int wf, input int wd, input int stop_st);
        bit ab;
        bit rnd;
        q.delete();
        add_mem(0, wf, ab);
        case (o)
            LW: begin
                q.push_back('{1, 1'b0, 1'b0, 1'b0});
                q.push_back('{2, 1'b0, 1'b0, 1'b0});
                add_mem(3, wd, ab);
                if (!ab) q.push_back('{4, 1'b0, 1'b0, 1'b0});
            end
            SW: begin
                q.push_back('{1, 1'b0, 1'b0, 1'b0});
                q.push_back('{2, 1'b0, 1'b0, 1'b0});
                add_mem(5, wd, ab);
            end
            RT, IT: begin
                q.push_back('{1, 1'b0, 1'b0, 1'b0});
                q.push_back('{(o == RT) ? 6 : 7, 1'b0, !f3_alu_ok(f3), 1'b0});
                if (f3_alu_ok(f3)) q.push_back('{8, 1'b0, 1'b0, 1'b0});
            end
            BQ: begin
                q.push_back('{1, 1'b0, 1'b0, 1'b0});
                q.push_back('{9, 1'b0, f3 != 3'b000, 1'b0});
            end
            JL: begin
                q.push_back('{1, 1'b0, 1'b0, 1'b0});
                q.push_back('{10, 1'b0, 1'b0, 1'b0});
                q.push_back('{8, 1'b0, 1'b0, 1'b0});
            end
            default: q.push_back('{1, 1'b0, 1'b1, 1'b0});
        endcase
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        foreach (q[i]) begin
            if (q[i].st == stop_st) return;
            rnd = 1'($urandom);
            // mem_ready is randomised outside memory states, where it must not matter
            mem_ready = (q[i].st == 0 || q[i].st == 3 || q[i].st == 5) ? q[i].rdy : rnd;
            #1;
            chk("ctl", 32'({state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                            result_src, alu_src_a, alu_src_b, alu_control}),
                32'(exp_ctl(q[i].st, mem_ready, z, o, f3, f7)));
            chk("imm_src", 32'(imm_src), 32'(exp_imm(o)));
            chk("illegal", 32'(illegal), 32'(ill_m));
            chk("bus_error", 32'(bus_error), 32'(bus_m));
            if (q[i].set_ill) ill_m = 1'b1;
            if (q[i].set_bus) bus_m = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [6:0] ops [7];
        logic [2:0] f3s [4];
        int k, wf, wd;
        logic [2:0] f3;
        ops = '{LW, SW, RT, IT, BQ, JL, 7'b1110011};
        f3s = '{3'b000, 3'b010, 3'b110, 3'b111};

        reset = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        reset = 1'b1;

        // lw, no waits: 0,1,2,3,4
        run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 0, -1);
        // sw with 3 stalled MEMWRITE cycles
        run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 3, -1);
        // beq taken and not taken
        run_instr(BQ, 3'b000, 1'b0, 1'b1, 0, 0, -1);
        run_instr(BQ, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        // sub vs addi with funct7b5 set
        run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0, -1);
        run_instr(IT, 3'b000, 1'b1, 1'b0, 0, 0, -1);
        run_instr(JL, 3'b000, 1'b0, 1'b0, 1, 0, -1);
        // load stuck in MEMREAD: times out after TO cycles
        run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 10, -1);
        // fetch timeout then retry
        run_instr(RT, 3'b111, 1'b0, 1'b0, TO + 1, 0, -1);
        // illegal op, then reset in the middle of a store
        run_instr(7'b1110011, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 0, 5);
        mem_ready = 1'b0;
        #1;
        chk("mw_pre_req", 32'(mem_req & mem_write), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_req", 32'(mem_req), 32'd0);
        chk("rst_mid_wr", 32'(mem_write), 32'd0);
        chk("rst_mid_ill", 32'(illegal), 32'd0);
        chk("rst_mid_bus", 32'(bus_error), 32'd0);
        chk("rst_mid_state", 32'(state), 32'd0);
        ill_m = 1'b0;
        bus_m = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // random instruction stream
        for (int n = 0; n < 60; n++) begin
            k  = int'($urandom_range(0, 6));
            f3 = f3s[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
            if (ops[k] == BQ && $urandom_range(0, 3) != 0) f3 = 3'b000;
            wf = ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(0, 3));
            wd = ($urandom_range(0, 9) == 0) ? TO     : int'($urandom_range(0, 3));
            run_instr(ops[k], f3, 1'($urandom), 1'($urandom), wf, wd, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
